ret_stack_ctrl: RTL and testbench
=================================

// Module: ret_stack_ctrl
// PURPOSE
//  Controller and storage for the speculative return-address stack (RAS) used by the fetch-stage predictor.
//  Fetch pushes return addresses on predicted calls and pops them on predicted returns.
//  The commit stage mirrors the same operations to keep a committed TOS pointer and depth.
//  A pipeline flush restores the speculative pointer and depth to their committed values.
// PARAMETERS
//  DEPTH      16            number of stack entries (RET_STACK_SIZE); power of two
//  PTR_W      4             pointer width, log2(DEPTH) (RET_PRED_POINTER_SIZE)
//  ADDR_W     32            return address width
//  EMPTY_ADDR 32'hF0000000  prediction driven when stack empty (kernel_adr)
// PORTS
//  clk            in   1        clock
//  reset          in   1        asynchronous reset, active-high
//  push_valid_i   in   1        speculative push (predicted call)
//  push_addr_i    in   ADDR_W   return address to push (call PC + 4)
//  pop_valid_i    in   1        speculative pop (predicted return)
//  commit_push_i  in   1        committed call retired
//  commit_pop_i   in   1        committed return retired
//  flush_i        in   1        misprediction/exception flush
//  pred_valid_o   out  1        stack non-empty; pred_addr_o is a real entry
//  pred_addr_o    out  ADDR_W   current top-of-stack address (EMPTY_ADDR if empty)
//  count_o        out  PTR_W+1  speculative depth, 0..DEPTH
//  empty_o        out  1        count_o == 0
//  full_o         out  1        count_o == DEPTH
//  overflow_o     out  1        1-cycle pulse: push while full
//  underflow_o    out  1        1-cycle pulse: pop (without push) while empty
// BEHAVIOUR
//  - Reset (async): spec_tos = commit_tos = DEPTH-1; spec_cnt = commit_cnt = 0.
//    All entries = EMPTY_ADDR; overflow_o = underflow_o = 0.
//    Hence after reset pred_valid_o = 0 and pred_addr_o = EMPTY_ADDR.
//  - pred_addr_o/pred_valid_o: combinational from registered state (entry[spec_tos], spec_cnt != 0).
//    Zero-latency read; any update becomes visible the next cycle.
//  - Priority per cycle: flush_i > (push & pop) > push > pop.
//  - flush_i: spec_tos <= commit_tos' and spec_cnt <= commit_cnt'.
//    Primed values include this cycle's commit ops.
//    push_valid_i and pop_valid_i are ignored; entries are not written.
//  - Push only: entry[spec_tos+1] <= push_addr_i; spec_tos += 1 (mod DEPTH).
//    spec_cnt = min(spec_cnt+1, DEPTH).
//    When full, the oldest entry is overwritten (wrap); overflow_o pulses.
//  - Pop only: when spec_cnt > 0, spec_tos -= 1 (mod DEPTH) and spec_cnt -= 1.
//    When empty: no state change; underflow_o pulses.
//  - Push & pop same cycle (coroutine jalr): the popped value is the old top, visible this cycle.
//    entry[spec_tos] <= push_addr_i; spec_tos unchanged.
//    If empty: treated as push only (cnt becomes 1, no underflow).
//  - Commit ops use the same arithmetic on commit_tos/commit_cnt, with commit_cnt saturating at DEPTH.
//    commit push & pop together: no change.
//    Commit ops never write entries and are applied even on flush cycles.
//  - Entries are shared between the speculative and committed views.
//    Speculative pushes past the committed top may overwrite committed entries.
//    This is accepted predictor inaccuracy, never a functional error.
//  - Width rules: pointers wrap naturally in PTR_W bits; counters are PTR_W+1 bits and never exceed DEPTH.
//  - Reset asserted mid-operation: all state returns to reset values immediately; inputs are ignored while reset = 1.
// TESTING
//  1. Reset -> pred_valid_o=0, pred_addr_o=32'hF0000000, count_o=0, empty_o=1.
//  2. Push 0x100,0x200,0x300, then pop x3 -> pred_addr_o 0x300,0x200,0x100, then empty, count_o=0.
//  3. 17 pushes 0x1000+4*i (i=0..16) -> full_o=1, overflow_o on 17th.
//     16 pops return 0x1040 down to 0x1004.
//  4. Pop while empty -> underflow_o=1 for one cycle; count_o=0; pred_addr_o=32'hF0000000.
//  5. commit_push 0xA0 (after push), spec push 0xB0,0xC0, pop x1, flush_i -> count_o=1, pred_addr_o=0xA0.
//  6. Stack [0x10,0x20], push 0x30 & pop same cycle -> pred 0x20 that cycle.
//     Next cycle top=0x30, count_o=2.
//     flush_i with push_valid_i -> push ignored.

Source files
------------

// File: rtl/ret_stack_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack_ctrl_if
//  Description : Fetch/commit side bundle of the return-address stack.
//                The master drives push/pop/commit/flush requests and
//                observes the prediction and status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ret_stack_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int PTR_W  = 4
);
   logic              push_valid_i;
   logic [ADDR_W-1:0] push_addr_i;
   logic              pop_valid_i;
   logic              commit_push_i;
   logic              commit_pop_i;
   logic              flush_i;
   logic              pred_valid_o;
   logic [ADDR_W-1:0] pred_addr_o;
   logic [PTR_W:0]    count_o;
   logic              empty_o;
   logic              full_o;
   logic              overflow_o;
   logic              underflow_o;

   modport master (
      output push_valid_i, push_addr_i, pop_valid_i,
             commit_push_i, commit_pop_i, flush_i,
      input  pred_valid_o, pred_addr_o, count_o,
             empty_o, full_o, overflow_o, underflow_o
   );

   modport slave (
      input  push_valid_i, push_addr_i, pop_valid_i,
             commit_push_i, commit_pop_i, flush_i,
      output pred_valid_o, pred_addr_o, count_o,
             empty_o, full_o, overflow_o, underflow_o
   );
endinterface
`default_nettype wire

// File: rtl/ret_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack_ctrl
//  Description : Speculative return-address stack with a committed shadow
//                pointer/depth. Flush restores the speculative view from the
//                committed one; entry storage is shared by both views.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack_ctrl #(
   parameter int                DEPTH      = 16,
   parameter int                PTR_W      = 4,
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] EMPTY_ADDR = 32'hF000_0000
) (
   input  logic             clk,
   input  logic             reset,
   ret_stack_ctrl_if.slave  bus
);

   localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
   localparam logic [PTR_W-1:0] c_ptr_top = PTR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] r_entry [DEPTH];
   logic [PTR_W-1:0]  r_spec_tos,   w_spec_tos_nxt;
   logic [PTR_W:0]    r_spec_cnt,   w_spec_cnt_nxt;
   logic [PTR_W-1:0]  r_commit_tos, w_commit_tos_nxt;
   logic [PTR_W:0]    r_commit_cnt, w_commit_cnt_nxt;
   logic              w_wr_en;
   logic [PTR_W-1:0]  w_wr_idx;
   logic              w_overflow_nxt, w_underflow_nxt;
   logic              r_overflow, r_underflow;

   // Committed pointer/depth update; simultaneous push and pop cancel out
   always_comb begin
      w_commit_tos_nxt = r_commit_tos;
      w_commit_cnt_nxt = r_commit_cnt;
      if (bus.commit_push_i && !bus.commit_pop_i) begin
         w_commit_tos_nxt = r_commit_tos + c_ptr_one;
         if (r_commit_cnt != c_depth)
            w_commit_cnt_nxt = r_commit_cnt + c_cnt_one;
      end else if (bus.commit_pop_i && !bus.commit_push_i && (r_commit_cnt != '0)) begin
         w_commit_tos_nxt = r_commit_tos - c_ptr_one;
         w_commit_cnt_nxt = r_commit_cnt - c_cnt_one;
      end
   end

   // Speculative pointer/depth update, entry write request and status pulses
   always_comb begin
      w_spec_tos_nxt  = r_spec_tos;
      w_spec_cnt_nxt  = r_spec_cnt;
      w_wr_en         = 1'b0;
      w_wr_idx        = r_spec_tos + c_ptr_one;
      w_overflow_nxt  = 1'b0;
      w_underflow_nxt = 1'b0;
      if (bus.flush_i) begin
         // Restore from the committed view including this cycle's commits
         w_spec_tos_nxt = w_commit_tos_nxt;
         w_spec_cnt_nxt = w_commit_cnt_nxt;
      end else if (bus.push_valid_i && bus.pop_valid_i && (r_spec_cnt != '0)) begin
         // Coroutine return+call: replace the top in place
         w_wr_en  = 1'b1;
         w_wr_idx = r_spec_tos;
      end else if (bus.push_valid_i) begin
         // Covers push+pop on an empty stack, which degrades to a push
         w_wr_en        = 1'b1;
         w_spec_tos_nxt = r_spec_tos + c_ptr_one;
         if (r_spec_cnt == c_depth)
            w_overflow_nxt = !bus.pop_valid_i;
         else
            w_spec_cnt_nxt = r_spec_cnt + c_cnt_one;
      end else if (bus.pop_valid_i) begin
         if (r_spec_cnt != '0) begin
            w_spec_tos_nxt = r_spec_tos - c_ptr_one;
            w_spec_cnt_nxt = r_spec_cnt - c_cnt_one;
         end else begin
            w_underflow_nxt = 1'b1;
         end
      end
   end

   // Pointer, depth and pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_spec_tos   <= c_ptr_top;
         r_spec_cnt   <= '0;
         r_commit_tos <= c_ptr_top;
         r_commit_cnt <= '0;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         r_spec_tos   <= w_spec_tos_nxt;
         r_spec_cnt   <= w_spec_cnt_nxt;
         r_commit_tos <= w_commit_tos_nxt;
         r_commit_cnt <= w_commit_cnt_nxt;
         r_overflow   <= w_overflow_nxt;
         r_underflow  <= w_underflow_nxt;
      end
   end

   // Entry storage; only speculative pushes write it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_entry[i] <= EMPTY_ADDR;
      end else if (w_wr_en) begin
         r_entry[w_wr_idx] <= bus.push_addr_i;
      end
   end

   assign bus.pred_valid_o = (r_spec_cnt != '0);
   assign bus.pred_addr_o  = bus.pred_valid_o ? r_entry[r_spec_tos] : EMPTY_ADDR;
   assign bus.count_o      = r_spec_cnt;
   assign bus.empty_o      = (r_spec_cnt == '0);
   assign bus.full_o       = (r_spec_cnt == c_depth);
   assign bus.overflow_o   = r_overflow;
   assign bus.underflow_o  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ret_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ret_stack_ctrl
//  Description : Scoreboard bench for ret_stack_ctrl. Each driven cycle
//                queues the expected post-edge outputs, which are popped and
//                compared once the edge has been taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ret_stack_ctrl;

   localparam logic [31:0] c_empty = 32'hF000_0000;

   typedef struct {
      string       tag;
      logic        valid;
      logic [31:0] addr;
      logic [4:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];

   ret_stack_ctrl_if #(.ADDR_W(32), .PTR_W(4)) bus ();

   ret_stack_ctrl #(
      .DEPTH(16), .PTR_W(4), .ADDR_W(32), .EMPTY_ADDR(32'hF000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic v, input logic [31:0] a,
                           input logic [4:0] c, input logic o, input logic u);
      exp_t e;
      e.tag = tag; e.valid = v; e.addr = a; e.cnt = c; e.ovf = o; e.unf = u;
      exp_q.push_back(e);
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 64'd0, 64'd1);
         return;
      end
      e = exp_q.pop_front();
      check({e.tag, ".valid"}, 64'(bus.pred_valid_o), 64'(e.valid));
      check({e.tag, ".addr"},  64'(bus.pred_addr_o),  64'(e.addr));
      check({e.tag, ".count"}, 64'(bus.count_o),      64'(e.cnt));
      check({e.tag, ".empty"}, 64'(bus.empty_o),      64'(e.cnt == 5'd0));
      check({e.tag, ".full"},  64'(bus.full_o),       64'(e.cnt == 5'd16));
      check({e.tag, ".ovf"},   64'(bus.overflow_o),   64'(e.ovf));
      check({e.tag, ".unf"},   64'(bus.underflow_o),  64'(e.unf));
   endtask

   // One clocked transaction: drive, queue expectation, take edge, compare
   task automatic cyc(input string tag, input logic push, input logic [31:0] addr,
                      input logic pop, input logic cpush, input logic cpop, input logic flush,
                      input logic ev, input logic [31:0] ea, input logic [4:0] ec,
                      input logic eo, input logic eu);
      bus.push_valid_i  = push;
      bus.push_addr_i   = addr;
      bus.pop_valid_i   = pop;
      bus.commit_push_i = cpush;
      bus.commit_pop_i  = cpop;
      bus.flush_i       = flush;
      push_exp(tag, ev, ea, ec, eo, eu);
      @(posedge clk);
      #1;
      bus.push_valid_i  = 1'b0;
      bus.push_addr_i   = '0;
      bus.pop_valid_i   = 1'b0;
      bus.commit_push_i = 1'b0;
      bus.commit_pop_i  = 1'b0;
      bus.flush_i       = 1'b0;
      compare_out();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus.push_valid_i  = 1'b0;
      bus.push_addr_i   = '0;
      bus.pop_valid_i   = 1'b0;
      bus.commit_push_i = 1'b0;
      bus.commit_pop_i  = 1'b0;
      bus.flush_i       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      push_exp("reset", 1'b0, c_empty, 5'd0, 1'b0, 1'b0);
      compare_out();
      reset = 1'b0;

      // Basic LIFO ordering
      cyc("push100", 1, 32'h100, 0, 0, 0, 0, 1, 32'h100, 5'd1, 0, 0);
      cyc("push200", 1, 32'h200, 0, 0, 0, 0, 1, 32'h200, 5'd2, 0, 0);
      cyc("push300", 1, 32'h300, 0, 0, 0, 0, 1, 32'h300, 5'd3, 0, 0);
      cyc("pop1",    0, 32'h0,   1, 0, 0, 0, 1, 32'h200, 5'd2, 0, 0);
      cyc("pop2",    0, 32'h0,   1, 0, 0, 0, 1, 32'h100, 5'd1, 0, 0);
      cyc("pop3",    0, 32'h0,   1, 0, 0, 0, 0, c_empty, 5'd0, 0, 0);

      // Fill past capacity: oldest entry lost, overflow on the 17th push
      for (int i = 0; i < 17; i++)
         cyc($sformatf("fill%0d", i), 1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0,
             1, 32'h1000 + 32'(4 * i), (i >= 15) ? 5'd16 : 5'(i + 1), (i == 16), 0);
      for (int j = 0; j < 16; j++)
         cyc($sformatf("drain%0d", j), 0, 32'h0, 1, 0, 0, 0,
             (j != 15), (j == 15) ? c_empty : 32'h1040 - 32'(4 * (j + 1)),
             5'(15 - j), 0, 0);

      // Underflow pulse is one cycle long and changes nothing
      cyc("underflow", 0, 32'h0, 1, 0, 0, 0, 0, c_empty, 5'd0, 0, 1);
      cyc("unf_clear", 0, 32'h0, 0, 0, 0, 0, 0, c_empty, 5'd0, 0, 0);

      // Flush restores the committed view
      cyc("align_flush", 0, 32'h0,  0, 0, 0, 1, 0, c_empty, 5'd0, 0, 0);
      cyc("pushA0_cmt",  1, 32'hA0, 0, 1, 0, 0, 1, 32'hA0,  5'd1, 0, 0);
      cyc("pushB0",      1, 32'hB0, 0, 0, 0, 0, 1, 32'hB0,  5'd2, 0, 0);
      cyc("pushC0",      1, 32'hC0, 0, 0, 0, 0, 1, 32'hC0,  5'd3, 0, 0);
      cyc("popC0",       0, 32'h0,  1, 0, 0, 0, 1, 32'hB0,  5'd2, 0, 0);
      cyc("flush_A0",    0, 32'h0,  0, 0, 0, 1, 1, 32'hA0,  5'd1, 0, 0);

      // Simultaneous push and pop replaces the top
      cyc("pop_cmt",  0, 32'h0,  1, 0, 1, 0, 0, c_empty, 5'd0, 0, 0);
      cyc("push10",   1, 32'h10, 0, 0, 0, 0, 1, 32'h10,  5'd1, 0, 0);
      cyc("push20",   1, 32'h20, 0, 0, 0, 0, 1, 32'h20,  5'd2, 0, 0);
      bus.push_valid_i = 1'b1;
      bus.push_addr_i  = 32'h30;
      bus.pop_valid_i  = 1'b1;
      #1;
      push_exp("pushpop_now", 1, 32'h20, 5'd2, 0, 0);
      compare_out();
      cyc("pushpop30", 1, 32'h30, 1, 0, 0, 0, 1, 32'h30, 5'd2, 0, 0);
      cyc("flush_ign_push", 1, 32'h40, 0, 0, 0, 1, 0, c_empty, 5'd0, 0, 0);

      // Push+pop on empty acts as push; commits apply on flush cycles
      cyc("pushpop_empty", 1, 32'h50, 1, 0, 0, 0, 1, 32'h50, 5'd1, 0, 0);
      cyc("flush_w_cmt",   0, 32'h0,  0, 1, 0, 1, 1, 32'h50, 5'd1, 0, 0);
      cyc("cmt_both_pop",  0, 32'h0,  1, 1, 1, 0, 0, c_empty, 5'd0, 0, 0);
      cyc("flush_again",   0, 32'h0,  0, 0, 0, 1, 1, 32'h50, 5'd1, 0, 0);

      // Asynchronous reset in mid-cycle, with inputs active
      cyc("pre_rst_push", 1, 32'h77, 0, 0, 0, 0, 1, 32'h77, 5'd2, 0, 0);
      #3;
      bus.push_valid_i = 1'b1;
      bus.push_addr_i  = 32'h99;
      reset = 1'b1;
      #1;
      push_exp("async_rst", 0, c_empty, 5'd0, 0, 0);
      compare_out();
      @(posedge clk);
      #1;
      push_exp("rst_held", 0, c_empty, 5'd0, 0, 0);
      compare_out();
      reset = 1'b0;
      bus.push_valid_i = 1'b0;
      bus.push_addr_i  = '0;
      cyc("post_rst_pop", 0, 32'h0, 1, 0, 0, 0, 0, c_empty, 5'd0, 0, 1);

      if (exp_q.size() != 0)
         check("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
